bus_rr_router: RTL and testbench
================================

Name: bus_rr_router

Overview:
Parametrised successor to the single-bus generator/arbiter. It serves DRVRS terminals, each of which has a source FIFO (pndng/D_pop/pop) and a sink FIFO (push/D_push). Each cycle slot it grants one pending terminal using round-robin or fixed priority, pops one packet, decodes the destination ID in the packet's upper bits, and pushes the packet to one terminal or broadcasts it to all others. It sits between the per-terminal FIFOs that the driver agents model on the bench.

Parameters:
DRVRS, 4, number of terminals (2..16)
PCKG_SZ, 16, packet width in bits
ID_W, 8, destination ID field width: packet bits [PCKG_SZ-1 : PCKG_SZ-ID_W]
BROADCAST, 8'hFF, ID value meaning "deliver to every terminal except the source"
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  synchronous, active-high
pndng  in  DRVRS  source FIFO i is non-empty
D_pop  in  DRVRS*PCKG_SZ  head word of source FIFO i, slice [i*PCKG_SZ +: PCKG_SZ]
pop  out  DRVRS  one-cycle pop strobe to source FIFO i
push  out  DRVRS  one-cycle push strobe to sink FIFO i
D_push  out  DRVRS*PCKG_SZ  packet to sink FIFO i, same slicing as D_pop
grant_id  out  $clog2(DRVRS)  index of the current or last granted terminal
busy  out  1  high while a packet is in flight (states POP and PUSH)
err_id  out  1  one-cycle pulse when a packet is dropped

Behaviour:
- Reset values: pop=0, push=0, D_push=0, grant_id=0, busy=0, err_id=0; FSM=IDLE; rr pointer=DRVRS-1, so terminal 0 wins first.
- FSM has three states: IDLE, POP, PUSH.
- IDLE: if any pndng bit is set, arbitrate, register the winner in grant_id, and go to POP. Otherwise stay in IDLE.
- POP:
  - Assert pop[grant_id] for exactly one cycle.
  - Latch pkt = D_pop slice of grant_id in the same cycle.
  - Go to PUSH.
- PUSH: decode id = pkt[PCKG_SZ-1 -: ID_W], then act on it:
  - id < DRVRS and id != grant_id: push[id]=1.
  - id == BROADCAST: push[i]=1 for every i != grant_id.
  - Otherwise (out of range, or self-addressed): no push, err_id=1.
- PUSH exit: in the same cycle, arbitrate on the current pndng. If any bit is set, go to POP with the new grant; else go to IDLE.
- Back-to-back throughput is one packet per 2 cycles.
- Latency: pndng rising in IDLE gives pop at edge+1 and push at edge+2.
- D_push drives pkt to every slice while in PUSH and holds its value otherwise. It is meaningful only where push is set.
- Round-robin arbitration:
  - Search from pointer+1 upward, wrapping modulo DRVRS; the first set pndng bit wins.
  - The pointer updates to the winner when the POP state is entered.
- Fixed priority: the lowest set index wins, and the pointer is ignored.
- pop, push and err_id are never asserted in the same cycle. At most one pop bit is set per cycle.
- Reset asserted in any state aborts the in-flight packet at the next edge: no push, no err_id, and all outputs take their reset values. A packet already popped is lost.
- pndng dropping between grant and POP is a FIFO protocol violation. The block still pops; the bench must not generate this case.

Test Plan:
1. Terminal 0 holds 16'h0203 (ID 2) → pop[0] at edge+1, push=4'b0100 with D_push slice 2 = 16'h0203 at edge+2, err_id=0.
2. Terminal 1 holds 16'hFF55 → push=4'b1101 in PUSH and push[1]=0; every pushed slice = 16'hFF55.
3. PRIO_MODE=0, all four pndng held high, each packet ID valid → grant_id sequence 0,1,2,3,0; pops 2 cycles apart.
4. PRIO_MODE=1, pndng=4'b1010 held high → grant_id stays 1 and terminal 3 is never popped.
5. Packets 16'h0700 (ID 7 ≥ DRVRS) and 16'h0000 from terminal 0 (self-addressed) → each is popped, push=0, one err_id pulse per packet.
6. Reset asserted in the POP cycle of a 0→3 transfer → no push[3]; outputs are 0 and the FSM is IDLE at the next edge; the next grant goes to terminal 0.

Source files
------------

// File: rtl/bus_rr_router.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_router
// Description : Single-bus router. Each slot it grants one pending source FIFO
//               by round-robin or fixed priority, pops one packet and pushes it
//               to the addressed sink FIFO or broadcasts it to the others.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_router #(
    parameter int              DRVRS     = 4,
    parameter int              PCKG_SZ   = 16,
    parameter int              ID_W      = 8,
    parameter logic [ID_W-1:0] BROADCAST = ID_W'(8'hFF),
    parameter int              PRIO_MODE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DRVRS-1:0]           pndng,
    input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]           pop,
    output logic [DRVRS-1:0]           push,
    output logic [DRVRS*PCKG_SZ-1:0]   D_push,
    output logic [$clog2(DRVRS)-1:0]   grant_id,
    output logic                       busy,
    output logic                       err_id
);

    localparam int GW = $clog2(DRVRS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [GW-1:0]       r_ptr;
    logic [GW-1:0]       r_grant;
    logic [GW-1:0]       w_win;
    logic                w_any;
    logic [PCKG_SZ-1:0]  r_pkt;
    logic [ID_W-1:0]     w_id;
    logic                w_uni;
    logic                w_bcast;

    // Candidates are scanned from the lowest priority to the highest so the
    // last assignment made is the winner.
    always_comb begin
        int idx;
        w_any = |pndng;
        w_win = '0;
        idx   = 0;
        if (PRIO_MODE != 0) begin
            for (int k = DRVRS - 1; k >= 0; k--) begin
                if (pndng[k]) w_win = GW'(k);
            end
        end else begin
            for (int k = DRVRS; k >= 1; k--) begin
                idx = (int'(r_ptr) + k) % DRVRS;
                if (pndng[idx]) w_win = GW'(idx);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_POP;
            S_POP:   w_next = S_PUSH;
            S_PUSH:  w_next = w_any ? S_POP : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= GW'(DRVRS - 1);
            r_grant <= '0;
            r_pkt   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE || r_state == S_PUSH) && w_any) begin
                r_grant <= w_win;
                r_ptr   <= w_win;
            end
            if (r_state == S_POP) begin
                r_pkt <= D_pop[int'(r_grant)*PCKG_SZ +: PCKG_SZ];
            end
        end
    end

    assign w_id    = r_pkt[PCKG_SZ-1 -: ID_W];
    assign w_uni   = (32'(w_id) < DRVRS) && (32'(w_id) != 32'(r_grant));
    assign w_bcast = !w_uni && (w_id == BROADCAST);

    always_comb begin
        pop    = '0;
        push   = '0;
        err_id = 1'b0;
        if (r_state == S_POP) begin
            pop[r_grant] = 1'b1;
        end
        if (r_state == S_PUSH) begin
            for (int i = 0; i < DRVRS; i++) begin
                push[i] = (w_uni && (32'(w_id) == i)) ||
                          (w_bcast && (r_grant != GW'(i)));
            end
            err_id = !w_uni && !w_bcast;
        end
    end

    // The latched packet is fanned out to every sink; push selects who takes it.
    generate
        for (genvar i = 0; i < DRVRS; i++) begin : g_dpush
            assign D_push[i*PCKG_SZ +: PCKG_SZ] = r_pkt;
        end
    endgenerate

    assign grant_id = r_grant;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_rr_router
// Description : Self-checking bench for bus_rr_router with source FIFO models
//               and a packet-level round-robin / priority reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_rr_router;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  pndng;
    logic [N*16-1:0] d_pop;
    logic [N-1:0]  pop, push;
    logic [N*16-1:0] d_push;
    logic [1:0]    grant_id;
    logic          busy, err_id;

    logic [N-1:0]  p_pndng;
    logic [N*16-1:0] p_dpop;
    logic [N-1:0]  p_pop, p_push;
    logic [N*16-1:0] p_dpush;
    logic [1:0]    p_grant;
    logic          p_busy, p_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_rr_router #(.DRVRS(N), .PCKG_SZ(16), .ID_W(8), .BROADCAST(8'hFF), .PRIO_MODE(0)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop), .push(push),
        .D_push(d_push), .grant_id(grant_id), .busy(busy), .err_id(err_id));

    bus_rr_router #(.DRVRS(N), .PCKG_SZ(16), .ID_W(8), .BROADCAST(8'hFF), .PRIO_MODE(1)) dut_prio (
        .clk(clk), .reset(reset), .pndng(p_pndng), .D_pop(p_dpop), .pop(p_pop), .push(p_push),
        .D_push(p_dpush), .grant_id(p_grant), .busy(p_busy), .err_id(p_err));

    // Source FIFO models
    logic [15:0] mem [N][256];
    int qh [N];
    int qt [N];

    // Reference transactions
    int          eg [64];
    logic [15:0] ep [64];
    logic [3:0]  em [64];
    bit          ee [64];
    int          n_exp;
    int          m_ptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            pndng[i] = (qh[i] < qt[i]);
            d_pop[i*16 +: 16] = (qh[i] < qt[i]) ? mem[i][qh[i]] : 16'h0;
        end
    endtask

    task automatic load(input int t, input logic [15:0] pkt);
        mem[t][qt[t]] = pkt;
        qt[t]++;
    endtask

    // Packet-level model: drain all queues by round-robin and derive deliveries.
    task automatic build_expected();
        int th [N];
        int win, id;
        for (int i = 0; i < N; i++) th[i] = qh[i];
        n_exp = 0;
        forever begin
            win = -1;
            for (int k = 1; k <= N && win < 0; k++) begin
                if (th[(m_ptr + k) % N] < qt[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            if (win < 0) break;
            m_ptr = win;
            ep[n_exp] = mem[win][th[win]];
            th[win]++;
            eg[n_exp] = win;
            id = int'(ep[n_exp][15:8]);
            if (id < N && id != win) begin
                em[n_exp] = 4'(1 << id);
                ee[n_exp] = 1'b0;
            end else if (id == 255) begin
                em[n_exp] = 4'hF & ~4'(1 << win);
                ee[n_exp] = 1'b0;
            end else begin
                em[n_exp] = 4'h0;
                ee[n_exp] = 1'b1;
            end
            n_exp++;
        end
    endtask

    // Queues are all loaded before release, so the backlog is continuous:
    // pop at odd cycles, delivery one cycle later.
    task automatic run_traffic(input string tag);
        logic [3:0] exp_pop, exp_push, popped;
        bit exp_err;
        int t, u;
        build_expected();
        refresh();
        for (int cyc = 0; cyc <= 2 * n_exp + 1; cyc++) begin
            @(negedge clk);
            t = (cyc - 1) / 2;
            exp_pop  = (cyc % 2 == 1 && cyc <= 2 * n_exp - 1) ? 4'(1 << eg[t]) : 4'h0;
            exp_push = 4'h0;
            exp_err  = 1'b0;
            u = 0;
            if (cyc >= 2 && cyc % 2 == 0) begin
                u = (cyc - 2) / 2;
                exp_push = em[u];
                exp_err  = ee[u];
                for (int i = 0; i < N; i++)
                    if (em[u][i]) chk({tag, "_dpush"}, 64'(d_push[i*16 +: 16]), 64'(ep[u]));
            end
            chk({tag, "_pop"},  64'(pop),    64'(exp_pop));
            chk({tag, "_push"}, 64'(push),   64'(exp_push));
            chk({tag, "_err"},  64'(err_id), 64'(exp_err));
            chk({tag, "_busy"}, 64'(busy),   64'(cyc >= 1 && cyc <= 2 * n_exp));
            if (cyc >= 1) chk({tag, "_grant"}, 64'(grant_id), 64'(eg[(t < n_exp) ? t : n_exp - 1]));
            popped = pop;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (popped[i] && qh[i] < qt[i]) qh[i]++;
            refresh();
        end
    endtask

    initial begin
        int lowest, sel, cnt;
        logic [7:0] id;
        for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end
        m_ptr   = N - 1;
        reset   = 1'b1;
        p_pndng = '0;
        p_dpop  = '0;
        refresh();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_pop", 64'(pop), 0);
        chk("rst_push", 64'(push), 0);
        chk("rst_dpush", 64'(d_push), 0);
        chk("rst_grant", 64'(grant_id), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err", 64'(err_id), 0);
        @(posedge clk); #1;

        // Fixed priority with terminals 1 and 3 always pending
        p_pndng = 4'b1010;
        p_dpop[1*16 +: 16] = 16'h0200;
        p_dpop[3*16 +: 16] = 16'h0000;
        lowest = -1;
        for (int i = N - 1; i >= 0; i--) if (p_pndng[i]) lowest = i;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            chk("prio_pop", 64'(p_pop), (cyc % 2 == 1) ? 64'(1 << lowest) : 64'h0);
            chk("prio_push", 64'(p_push), (cyc >= 2 && cyc % 2 == 0) ? 64'h4 : 64'h0);
            if (cyc >= 1) chk("prio_grant", 64'(p_grant), 64'(lowest));
            @(posedge clk); #1;
        end
        p_pndng = '0;

        load(0, 16'h0203);
        run_traffic("unicast");
        load(1, 16'hFF55);
        run_traffic("bcast");
        load(0, 16'h0111); load(1, 16'h0222); load(2, 16'h0333);
        load(3, 16'h0044); load(0, 16'h0355);
        run_traffic("rr4");
        load(0, 16'h0700); load(0, 16'h0000);
        run_traffic("drop");

        for (int r = 0; r < 20; r++) begin
            for (int t = 0; t < N; t++) begin
                cnt = $urandom_range(0, 3);
                for (int j = 0; j < cnt; j++) begin
                    sel = $urandom_range(0, 5);
                    id = (sel < 4) ? 8'(sel) : (sel == 4) ? 8'hFF : 8'($urandom_range(4, 254));
                    load(t, {id, 8'($urandom)});
                end
            end
            run_traffic("rand");
        end

        // Reset during POP of a 0 -> 3 transfer
        load(0, 16'h0300);
        refresh();
        @(negedge clk);
        chk("abort_idle", 64'(pop), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_pop", 64'(pop), 64'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        if (qh[0] < qt[0]) qh[0]++;
        reset = 1'b0;
        refresh();
        @(negedge clk);
        chk("abort_push", 64'(push), 0);
        chk("abort_err", 64'(err_id), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_grant", 64'(grant_id), 0);
        chk("abort_dpush", 64'(d_push), 0);
        chk("abort_pop2", 64'(pop), 0);
        @(posedge clk); #1;
        m_ptr = N - 1;
        load(1, 16'h0000); load(0, 16'h0101);
        run_traffic("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
